mc_ctrl: RTL and testbench

//  Multi-cycle control FSM for the MIPS-lite datapath (addu/subu/ori/lw/sw/beq/lui/j/jal/jr/nop).

---
 rtl/mc_ctrl_if.sv | 36 +++
 rtl/mc_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mc_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_if.sv
// Control/datapath bundle for mc_ctrl: instruction fields and memory handshake in,
// write enables, mux selects and status out.
interface mc_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             zero;
  logic             mem_rdy;
  logic             pc_we;
  logic             ir_we;
  logic             rf_we;
  logic             dm_we;
  logic [1:0]       npc_sel;
  logic [1:0]       alu_op;
  logic             alu_src_b;
  logic             ext_op;
  logic [1:0]       reg_dst;
  logic [1:0]       wd_sel;
  logic [2:0]       state;
  logic             instr_done;
  logic             illegal;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    output op, funct, zero, mem_rdy,
    input  pc_we, ir_we, rf_we, dm_we, npc_sel, alu_op, alu_src_b, ext_op,
    input  reg_dst, wd_sel, state, instr_done, illegal, instr_cnt
  );

  modport slave (
    input  op, funct, zero, mem_rdy,
    output pc_we, ir_we, rf_we, dm_we, npc_sel, alu_op, alu_src_b, ext_op,
    output reg_dst, wd_sel, state, instr_done, illegal, instr_cnt
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB control FSM for the MIPS-lite datapath, with a
// retired-instruction counter.
module mc_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input logic   clk,
  input logic   reset,
  mc_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StIf  = 3'd0,
    StId  = 3'd1,
    StEx  = 3'd2,
    StMem = 3'd3,
    StWb  = 3'd4
  } state_e;

  localparam logic [1:0] NpcSeq = 2'd0;
  localparam logic [1:0] NpcBr  = 2'd1;
  localparam logic [1:0] NpcJmp = 2'd2;
  localparam logic [1:0] NpcReg = 2'd3;

  localparam logic [1:0] AluAdd = 2'd0;
  localparam logic [1:0] AluSub = 2'd1;
  localparam logic [1:0] AluOr  = 2'd2;
  localparam logic [1:0] AluLui = 2'd3;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;

  logic       w_addu, w_subu, w_jr, w_nop, w_ori, w_lw, w_sw, w_beq, w_lui, w_j, w_jal;
  logic       w_rtype, w_illegal_dec;
  logic       w_pc_we, w_ir_we, w_rf_we, w_dm_we, w_alu_src_b, w_ext_op, w_done, w_illegal;
  logic [1:0] w_npc_sel, w_alu_op, w_reg_dst, w_wd_sel;

  always_comb begin
    w_rtype       = (bus.op == 6'h00);
    w_addu        = w_rtype && (bus.funct == 6'h21);
    w_subu        = w_rtype && (bus.funct == 6'h23);
    w_jr          = w_rtype && (bus.funct == 6'h08);
    w_nop         = w_rtype && (bus.funct == 6'h00);
    w_ori         = (bus.op == 6'h0d);
    w_lw          = (bus.op == 6'h23);
    w_sw          = (bus.op == 6'h2b);
    w_beq         = (bus.op == 6'h04);
    w_lui         = (bus.op == 6'h0f);
    w_j           = (bus.op == 6'h02);
    w_jal         = (bus.op == 6'h03);
    w_illegal_dec = !(w_addu || w_subu || w_jr || w_nop || w_ori || w_lw || w_sw ||
                      w_beq || w_lui || w_j || w_jal);
  end

  always_comb begin
    w_state_nxt = StIf;
    w_pc_we     = 1'b0;
    w_ir_we     = 1'b0;
    w_rf_we     = 1'b0;
    w_dm_we     = 1'b0;
    w_npc_sel   = NpcSeq;
    w_alu_op    = AluAdd;
    w_alu_src_b = 1'b0;
    w_ext_op    = 1'b0;
    w_reg_dst   = 2'd0;
    w_wd_sel    = 2'd0;
    w_done      = 1'b0;
    w_illegal   = 1'b0;

    case (r_state)
      StIf: begin
        w_pc_we     = bus.mem_rdy;
        w_ir_we     = bus.mem_rdy;
        w_state_nxt = bus.mem_rdy ? StId : StIf;
      end

      StId: begin
        w_state_nxt = StEx;
        if (w_j || w_jal) begin
          w_pc_we     = 1'b1;
          w_npc_sel   = NpcJmp;
          w_state_nxt = StIf;
          w_done      = 1'b1;
          if (w_jal) begin
            w_rf_we   = 1'b1;
            w_reg_dst = 2'd2;
            w_wd_sel  = 2'd2;
          end
        end else if (w_jr) begin
          w_pc_we     = 1'b1;
          w_npc_sel   = NpcReg;
          w_state_nxt = StIf;
          w_done      = 1'b1;
        end else if (w_nop || w_illegal_dec) begin
          w_illegal   = w_illegal_dec;
          w_state_nxt = StIf;
          w_done      = 1'b1;
        end
      end

      StEx: begin
        w_state_nxt = StWb;
        if (w_subu) begin
          w_alu_op = AluSub;
        end else if (w_ori) begin
          w_alu_op    = AluOr;
          w_alu_src_b = 1'b1;
        end else if (w_lui) begin
          w_alu_op    = AluLui;
          w_alu_src_b = 1'b1;
        end else if (w_lw || w_sw) begin
          w_alu_src_b = 1'b1;
          w_ext_op    = 1'b1;
          w_state_nxt = StMem;
        end else if (w_beq) begin
          // Branch target adder needs the sign-extended offset only when taken.
          w_alu_op    = AluSub;
          w_pc_we     = bus.zero;
          w_npc_sel   = bus.zero ? NpcBr : NpcSeq;
          w_ext_op    = bus.zero;
          w_state_nxt = StIf;
          w_done      = 1'b1;
        end
      end

      StMem: begin
        w_alu_src_b = 1'b1;
        w_ext_op    = 1'b1;
        w_dm_we     = w_sw;
        w_state_nxt = StMem;
        if (bus.mem_rdy) begin
          w_state_nxt = w_sw ? StIf : StWb;
          w_done      = w_sw;
        end
      end

      StWb: begin
        w_rf_we     = 1'b1;
        w_reg_dst   = w_rtype ? 2'd1 : 2'd0;
        w_wd_sel    = w_lw ? 2'd1 : 2'd0;
        w_state_nxt = StIf;
        w_done      = 1'b1;
      end

      default: w_state_nxt = StIf;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIf;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_done) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Outputs are forced low asynchronously so nothing writes while reset is held.
  assign bus.pc_we      = reset & w_pc_we;
  assign bus.ir_we      = reset & w_ir_we;
  assign bus.rf_we      = reset & w_rf_we;
  assign bus.dm_we      = reset & w_dm_we;
  assign bus.npc_sel    = reset ? w_npc_sel : 2'd0;
  assign bus.alu_op     = reset ? w_alu_op : 2'd0;
  assign bus.alu_src_b  = reset & w_alu_src_b;
  assign bus.ext_op     = reset & w_ext_op;
  assign bus.reg_dst    = reset ? w_reg_dst : 2'd0;
  assign bus.wd_sel     = reset ? w_wd_sel : 2'd0;
  assign bus.state      = reset ? r_state : 3'd0;
  assign bus.instr_done = reset & w_done;
  assign bus.illegal    = reset & w_illegal;
  assign bus.instr_cnt  = r_cnt;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: each driven cycle queues its expected outputs,
// a negedge monitor pops and compares.
module tb_mc_ctrl;
  localparam int unsigned CNT_W = 32;

  logic clk;
  logic reset;

  mc_ctrl_if #(.CNT_W(CNT_W)) bus ();

  mc_ctrl #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // {pc_we, ir_we, rf_we, dm_we, npc_sel, alu_op, alu_src_b, ext_op, reg_dst, wd_sel,
  //  state, instr_done, illegal}
  typedef logic [18:0] ctl_t;

  typedef struct {
    string      name;
    ctl_t       ctl;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctl_t cv(input int pc, ir, rf, dm, npc, alu, srcb, ext, rd, wd, st, dn,
                              il);
    return {1'(pc), 1'(ir), 1'(rf), 1'(dm), 2'(npc), 2'(alu), 1'(srcb), 1'(ext), 2'(rd),
            2'(wd), 3'(st), 1'(dn), 1'(il)};
  endfunction

  function automatic ctl_t got_ctl();
    return {bus.pc_we, bus.ir_we, bus.rf_we, bus.dm_we, bus.npc_sel, bus.alu_op,
            bus.alu_src_b, bus.ext_op, bus.reg_dst, bus.wd_sel, bus.state, bus.instr_done,
            bus.illegal};
  endfunction

  task automatic step(input string nm, input logic rst, input logic [5:0] o, f,
                      input logic z, r, input ctl_t e, input logic [31:0] ec);
    @(posedge clk);
    #1;
    reset       = rst;
    bus.op      = o;
    bus.funct   = f;
    bus.zero    = z;
    bus.mem_rdy = r;
    sb.push_back('{name: nm, ctl: e, cnt: ec});
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      ctl_t g;
      e = sb.pop_front();
      g = got_ctl();
      total++;
      if (g !== e.ctl || bus.instr_cnt !== e.cnt) begin
        bad++;
        $display("FAIL %s: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d",
                 e.name, g, bus.instr_cnt, e.ctl, e.cnt);
      end
    end
  end

  ctl_t c_fetch;
  ctl_t c_idle_id;

  initial begin
    c_fetch   = cv(1,1,0,0, 0,0,0,0, 0,0, 0,0,0);
    c_idle_id = cv(0,0,0,0, 0,0,0,0, 0,0, 1,0,0);
    reset       = 1'b1;
    bus.op      = 6'h23;
    bus.funct   = 6'h00;
    bus.zero    = 1'b0;
    bus.mem_rdy = 1'b1;
    #2 reset = 1'b0;

    // T1: reset holds everything low regardless of inputs
    step("rst_hold", 0, 6'h23, 6'h00, 1, 1, cv(0,0,0,0, 0,0,0,0, 0,0, 0,0,0), 0);
    step("rst_hold2", 0, 6'h23, 6'h21, 1, 1, cv(0,0,0,0, 0,0,0,0, 0,0, 0,0,0), 0);
    step("rst_rel", 1, 6'h23, 6'h00, 0, 1, c_fetch, 0);

    // T2: ori
    step("ori_id", 1, 6'h0d, 6'h00, 0, 1, c_idle_id, 0);
    step("ori_ex", 1, 6'h0d, 6'h00, 0, 1, cv(0,0,0,0, 0,2,1,0, 0,0, 2,0,0), 0);
    step("ori_wb", 1, 6'h0d, 6'h00, 0, 1, cv(0,0,1,0, 0,0,0,0, 0,0, 4,1,0), 0);

    // T3: lw with 3 wait cycles in MEM
    step("lw_if", 1, 6'h23, 6'h00, 0, 1, c_fetch, 1);
    step("lw_id", 1, 6'h23, 6'h00, 0, 1, c_idle_id, 1);
    step("lw_ex", 1, 6'h23, 6'h00, 0, 0, cv(0,0,0,0, 0,0,1,1, 0,0, 2,0,0), 1);
    step("lw_mem0", 1, 6'h23, 6'h00, 0, 0, cv(0,0,0,0, 0,0,1,1, 0,0, 3,0,0), 1);
    step("lw_mem1", 1, 6'h23, 6'h00, 0, 0, cv(0,0,0,0, 0,0,1,1, 0,0, 3,0,0), 1);
    step("lw_mem2", 1, 6'h23, 6'h00, 0, 0, cv(0,0,0,0, 0,0,1,1, 0,0, 3,0,0), 1);
    step("lw_mem3", 1, 6'h23, 6'h00, 0, 1, cv(0,0,0,0, 0,0,1,1, 0,0, 3,0,0), 1);
    step("lw_wb", 1, 6'h23, 6'h00, 0, 1, cv(0,0,1,0, 0,0,0,0, 0,1, 4,1,0), 1);

    // T4: sw with 2 wait cycles; IF stall first
    step("sw_if_stall", 1, 6'h2b, 6'h00, 0, 0, cv(0,0,0,0, 0,0,0,0, 0,0, 0,0,0), 2);
    step("sw_if", 1, 6'h2b, 6'h00, 0, 1, c_fetch, 2);
    step("sw_id", 1, 6'h2b, 6'h00, 0, 1, c_idle_id, 2);
    step("sw_ex", 1, 6'h2b, 6'h00, 0, 0, cv(0,0,0,0, 0,0,1,1, 0,0, 2,0,0), 2);
    step("sw_mem0", 1, 6'h2b, 6'h00, 0, 0, cv(0,0,0,1, 0,0,1,1, 0,0, 3,0,0), 2);
    step("sw_mem1", 1, 6'h2b, 6'h00, 0, 0, cv(0,0,0,1, 0,0,1,1, 0,0, 3,0,0), 2);
    step("sw_mem2", 1, 6'h2b, 6'h00, 0, 1, cv(0,0,0,1, 0,0,1,1, 0,0, 3,1,0), 2);

    // T5: beq taken, then not taken
    step("beq1_if", 1, 6'h04, 6'h00, 1, 1, c_fetch, 3);
    step("beq1_id", 1, 6'h04, 6'h00, 1, 1, c_idle_id, 3);
    step("beq1_ex", 1, 6'h04, 6'h00, 1, 1, cv(1,0,0,0, 1,1,0,1, 0,0, 2,1,0), 3);
    step("beq0_if", 1, 6'h04, 6'h00, 0, 1, c_fetch, 4);
    step("beq0_id", 1, 6'h04, 6'h00, 0, 1, c_idle_id, 4);
    step("beq0_ex", 1, 6'h04, 6'h00, 0, 1, cv(0,0,0,0, 0,1,0,0, 0,0, 2,1,0), 4);

    // T6: jal, then illegal opcode
    step("jal_if", 1, 6'h03, 6'h00, 0, 1, c_fetch, 5);
    step("jal_id", 1, 6'h03, 6'h00, 0, 1, cv(1,0,1,0, 2,0,0,0, 2,2, 1,1,0), 5);
    step("ill_if", 1, 6'h3f, 6'h00, 0, 1, c_fetch, 6);
    step("ill_id", 1, 6'h3f, 6'h00, 0, 1, cv(0,0,0,0, 0,0,0,0, 0,0, 1,1,1), 6);

    // Remaining decodes
    step("addu_if", 1, 6'h00, 6'h21, 0, 1, c_fetch, 7);
    step("addu_id", 1, 6'h00, 6'h21, 0, 1, c_idle_id, 7);
    step("addu_ex", 1, 6'h00, 6'h21, 0, 1, cv(0,0,0,0, 0,0,0,0, 0,0, 2,0,0), 7);
    step("addu_wb", 1, 6'h00, 6'h21, 0, 1, cv(0,0,1,0, 0,0,0,0, 1,0, 4,1,0), 7);
    step("subu_if", 1, 6'h00, 6'h23, 0, 1, c_fetch, 8);
    step("subu_id", 1, 6'h00, 6'h23, 0, 1, c_idle_id, 8);
    step("subu_ex", 1, 6'h00, 6'h23, 0, 1, cv(0,0,0,0, 0,1,0,0, 0,0, 2,0,0), 8);
    step("subu_wb", 1, 6'h00, 6'h23, 0, 1, cv(0,0,1,0, 0,0,0,0, 1,0, 4,1,0), 8);
    step("lui_if", 1, 6'h0f, 6'h00, 0, 1, c_fetch, 9);
    step("lui_id", 1, 6'h0f, 6'h00, 0, 1, c_idle_id, 9);
    step("lui_ex", 1, 6'h0f, 6'h00, 0, 1, cv(0,0,0,0, 0,3,1,0, 0,0, 2,0,0), 9);
    step("lui_wb", 1, 6'h0f, 6'h00, 0, 1, cv(0,0,1,0, 0,0,0,0, 0,0, 4,1,0), 9);
    step("jr_if", 1, 6'h00, 6'h08, 0, 1, c_fetch, 10);
    step("jr_id", 1, 6'h00, 6'h08, 0, 1, cv(1,0,0,0, 3,0,0,0, 0,0, 1,1,0), 10);
    step("j_if", 1, 6'h02, 6'h00, 0, 1, c_fetch, 11);
    step("j_id", 1, 6'h02, 6'h00, 0, 1, cv(1,0,0,0, 2,0,0,0, 0,0, 1,1,0), 11);
    step("nop_if", 1, 6'h00, 6'h00, 0, 1, c_fetch, 12);
    step("nop_id", 1, 6'h00, 6'h00, 0, 1, cv(0,0,0,0, 0,0,0,0, 0,0, 1,1,0), 12);
    step("illf_if", 1, 6'h00, 6'h3f, 0, 1, c_fetch, 13);
    step("illf_id", 1, 6'h00, 6'h3f, 0, 1, cv(0,0,0,0, 0,0,0,0, 0,0, 1,1,1), 13);

    // T7: reset in MEM of sw kills dm_we at once, then fetch resumes
    step("t7_if", 1, 6'h2b, 6'h00, 0, 1, c_fetch, 14);
    step("t7_id", 1, 6'h2b, 6'h00, 0, 1, c_idle_id, 14);
    step("t7_ex", 1, 6'h2b, 6'h00, 0, 0, cv(0,0,0,0, 0,0,1,1, 0,0, 2,0,0), 14);
    step("t7_mem", 1, 6'h2b, 6'h00, 0, 0, cv(0,0,0,1, 0,0,1,1, 0,0, 3,0,0), 14);
    step("t7_rst", 0, 6'h2b, 6'h00, 0, 0, cv(0,0,0,0, 0,0,0,0, 0,0, 0,0,0), 0);
    step("t7_if2", 1, 6'h02, 6'h00, 0, 1, c_fetch, 0);
    step("t7_j_id", 1, 6'h02, 6'h00, 0, 1, cv(1,0,0,0, 2,0,0,0, 0,0, 1,1,0), 0);
    step("t7_after", 1, 6'h02, 6'h00, 0, 0, cv(0,0,0,0, 0,0,0,0, 0,0, 0,0,0), 1);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
